// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } pipe_state_t;

  // Default abort threshold for data-memory wait states (timeout build only)
  localparam int unsigned MEM_TIMEOUT_DEF = 64;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_ADVANCE = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STAGE_BUBBLE  = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Data-memory request/ready handshake between the sequencer and data memory.
interface pipeline_ctrl_if;
  logic dmem_req_o;
  logic dmem_ready_i;

  modport master (output dmem_req_o, input dmem_ready_i);
  modport slave  (input dmem_req_o, output dmem_ready_i);
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads a register that the load in EX writes.
module hazard_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  output logic       load_use_o
);

  // x0 is never a real dependency, so rd==0 cannot stall
  always_comb begin
    load_use_o = ex_memread_i && (ex_rd_i != 5'd0) &&
                 ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                  (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Optional memory-wait timeout: define PIPE_CTRL_TIMEOUT_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
`ifdef PIPE_CTRL_TIMEOUT_EN
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
)
`endif
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_memread_i,
  input  logic       mem_memread_i,
  input  logic       mem_memwrite_i,
  input  logic       mem_redirect_i,
  pipeline_ctrl_if.master dmem,
  output logic       pc_en_o,
  output logic       if_id_en_o,
  output logic       id_ex_en_o,
  output logic       ex_mem_en_o,
  output logic       mem_wb_en_o,
  output logic       if_id_flush_o,
  output logic       id_ex_flush_o,
  output logic       ex_mem_flush_o,
  output logic       mem_wb_flush_o,
`ifdef PIPE_CTRL_TIMEOUT_EN
  output logic       timeout_o,
`endif
  output logic [1:0] state_o
);

  pipe_state_t state_q, state_d;
  stage_ctrl_t if_id, id_ex, ex_mem, mem_wb;
  logic        pc_en;
  logic        dmem_req;
  logic        mem_access;
  logic        load_use;
  logic        abort;

`ifdef PIPE_CTRL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  hazard_detect u_hazard_detect (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .ex_rd_i       (ex_rd_i),
    .ex_memread_i  (ex_memread_i),
    .load_use_o    (load_use)
  );

  // Next state and all stage controls; reset > memory wait > redirect > load-use
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b1;
    if_id      = STAGE_ADVANCE;
    id_ex      = STAGE_ADVANCE;
    ex_mem     = STAGE_ADVANCE;
    mem_wb     = STAGE_ADVANCE;
    dmem_req   = 1'b0;
    abort      = 1'b0;
    mem_access = mem_memread_i | mem_memwrite_i;
`ifdef PIPE_CTRL_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif

    if (reset_i) begin
      pc_en   = 1'b0;
      if_id   = STAGE_BUBBLE;
      id_ex   = STAGE_BUBBLE;
      ex_mem  = STAGE_BUBBLE;
      mem_wb  = STAGE_BUBBLE;
      state_d = RUN;
`ifdef PIPE_CTRL_TIMEOUT_EN
      cnt_d     = '0;
      timeout_d = 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (mem_access && !dmem.dmem_ready_i) begin
            dmem_req     = 1'b1;
            pc_en        = 1'b0;
            if_id.en     = 1'b0;
            id_ex.en     = 1'b0;
            ex_mem.en    = 1'b0;
            mem_wb.flush = 1'b1;
            state_d      = MEM_WAIT;
`ifdef PIPE_CTRL_TIMEOUT_EN
            cnt_d        = '0;
`endif
          end else begin
            dmem_req = mem_access;
            if (mem_redirect_i) begin
              if_id.flush  = 1'b1;
              id_ex.flush  = 1'b1;
              ex_mem.flush = 1'b1;
              state_d      = REDIRECT;
            end else if (load_use) begin
              pc_en       = 1'b0;
              if_id.en    = 1'b0;
              id_ex.flush = 1'b1;
            end
          end
        end
        MEM_WAIT: begin
`ifdef PIPE_CTRL_TIMEOUT_EN
          abort = !dmem.dmem_ready_i && (cnt_q == 16'(MEM_TIMEOUT - 1));
`endif
          // An abort retires the access like a ready, but without the request
          if (dmem.dmem_ready_i || abort) begin
            dmem_req = !abort;
            state_d  = RUN;
`ifdef PIPE_CTRL_TIMEOUT_EN
            if (abort) timeout_d = 1'b1;
`endif
            if (mem_redirect_i) begin
              if_id.flush  = 1'b1;
              id_ex.flush  = 1'b1;
              ex_mem.flush = 1'b1;
              state_d      = REDIRECT;
            end
          end else begin
            dmem_req     = 1'b1;
            pc_en        = 1'b0;
            if_id.en     = 1'b0;
            id_ex.en     = 1'b0;
            ex_mem.en    = 1'b0;
            mem_wb.en    = 1'b0;
            mem_wb.flush = 1'b1;
`ifdef PIPE_CTRL_TIMEOUT_EN
            cnt_d        = cnt_q + 16'd1;
`endif
          end
        end
        REDIRECT: begin
          if_id.flush = 1'b1;
          state_d     = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State register (plus timeout counter and sticky flag when enabled)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
`ifdef PIPE_CTRL_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef PIPE_CTRL_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Output mapping; state and flag read as zero while reset is held
  always_comb begin
    dmem.dmem_req_o = dmem_req;
    pc_en_o         = pc_en;
    if_id_en_o      = if_id.en;
    id_ex_en_o      = id_ex.en;
    ex_mem_en_o     = ex_mem.en;
    mem_wb_en_o     = mem_wb.en;
    if_id_flush_o   = if_id.flush;
    id_ex_flush_o   = id_ex.flush;
    ex_mem_flush_o  = ex_mem.flush;
    mem_wb_flush_o  = mem_wb.flush;
    state_o         = reset_i ? 2'd0 : state_q;
`ifdef PIPE_CTRL_TIMEOUT_EN
    timeout_o       = reset_i ? 1'b0 : timeout_q;
`endif
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       id_uses_rs1_i, id_uses_rs2_i, ex_memread_i;
  logic       mem_memread_i, mem_memwrite_i, mem_redirect_i;
  logic       pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic       if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o;
  logic [1:0] state_o;
`ifdef PIPE_CTRL_TIMEOUT_EN
  logic       timeout_o;
`endif

  pipeline_ctrl_if bus ();

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [11:0] exp_q[$];
  logic        exp_timeout = 1'b0;

  always #5 clk = ~clk;

`ifdef PIPE_CTRL_TIMEOUT_EN
  pipeline_ctrl #(.MEM_TIMEOUT(8)) dut (
`else
  pipeline_ctrl dut (
`endif
    .clk_i          (clk),
    .reset_i        (reset_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_uses_rs1_i  (id_uses_rs1_i),
    .id_uses_rs2_i  (id_uses_rs2_i),
    .ex_rd_i        (ex_rd_i),
    .ex_memread_i   (ex_memread_i),
    .mem_memread_i  (mem_memread_i),
    .mem_memwrite_i (mem_memwrite_i),
    .mem_redirect_i (mem_redirect_i),
    .dmem           (bus.master),
    .pc_en_o        (pc_en_o),
    .if_id_en_o     (if_id_en_o),
    .id_ex_en_o     (id_ex_en_o),
    .ex_mem_en_o    (ex_mem_en_o),
    .mem_wb_en_o    (mem_wb_en_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .ex_mem_flush_o (ex_mem_flush_o),
    .mem_wb_flush_o (mem_wb_flush_o),
`ifdef PIPE_CTRL_TIMEOUT_EN
    .timeout_o      (timeout_o),
`endif
    .state_o        (state_o)
  );

  // Expected vector: {req, en[pc,if_id,id_ex,ex_mem,mem_wb], flush[if_id,id_ex,ex_mem,mem_wb], state}
  function automatic logic [11:0] mk(input logic req, input logic [4:0] en,
                                     input logic [3:0] fl, input logic [1:0] st);
    return {req, en, fl, st};
  endfunction

  localparam logic [11:0] V_RESET     = {1'b0, 5'b00000, 4'b1111, 2'd0};
  localparam logic [11:0] V_NORMAL    = {1'b0, 5'b11111, 4'b0000, 2'd0};
  localparam logic [11:0] V_LOADUSE   = {1'b0, 5'b00111, 4'b0100, 2'd0};
  localparam logic [11:0] V_MEM_FAST  = {1'b1, 5'b11111, 4'b0000, 2'd0};
  localparam logic [11:0] V_MEM_STALL = {1'b1, 5'b00001, 4'b0001, 2'd0};
  localparam logic [11:0] V_WAIT      = {1'b1, 5'b00000, 4'b0001, 2'd1};
  localparam logic [11:0] V_WAIT_DONE = {1'b1, 5'b11111, 4'b0000, 2'd1};
  localparam logic [11:0] V_REDIR     = {1'b0, 5'b11111, 4'b1110, 2'd0};
  localparam logic [11:0] V_REDIR_ST  = {1'b0, 5'b11111, 4'b1000, 2'd2};

  task automatic clear_in();
    reset_i = 1'b0;
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0; ex_memread_i = 1'b0;
    mem_memread_i = 1'b0; mem_memwrite_i = 1'b0; mem_redirect_i = 1'b0;
    bus.dmem_ready_i = 1'b0;
  endtask

  // Push expectation with the stimulus, pop and compare mid-cycle, then advance
  task automatic check(input logic [11:0] e, input string tag);
    logic [11:0] obs;
    logic [11:0] want;
    exp_q.push_back(e);
    @(negedge clk);
    obs = {bus.dmem_req_o, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o, state_o};
    want = exp_q.pop_front();
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
`ifdef PIPE_CTRL_TIMEOUT_EN
    vectors++;
    assert (timeout_o === exp_timeout) else begin
      miscompares++;
      $error("FAIL %s timeout_o: observed %b expected %b", tag, timeout_o, exp_timeout);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    reset_i = 1'b1;
    @(posedge clk); #1;
    check(V_RESET, "reset");
    reset_i = 1'b0;
    check(V_NORMAL, "first_run");

    // load x5 ; add x6,x5,x1
    ex_memread_i = 1'b1; ex_rd_i = 5'd5;
    id_rs1_i = 5'd5; id_uses_rs1_i = 1'b1; id_rs2_i = 5'd1; id_uses_rs2_i = 1'b1;
    check(V_LOADUSE, "loaduse_rs1");
    id_rs1_i = 5'd1; id_rs2_i = 5'd5;
    check(V_LOADUSE, "loaduse_rs2");
    id_uses_rs2_i = 1'b0;
    check(V_NORMAL, "loaduse_unused_rs2");
    ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_uses_rs1_i = 1'b1;
    check(V_NORMAL, "loaduse_rd_x0");
    ex_rd_i = 5'd5; id_rs1_i = 5'd5; ex_memread_i = 1'b0;
    check(V_NORMAL, "no_load_no_stall");
    clear_in();

    // zero-wait load
    mem_memread_i = 1'b1; bus.dmem_ready_i = 1'b1;
    check(V_MEM_FAST, "mem_zero_wait");

    // store, ready low for 3 cycles
    clear_in();
    mem_memwrite_i = 1'b1;
    check(V_MEM_STALL, "store_stall0");
    check(V_WAIT, "store_wait1");
    check(V_WAIT, "store_wait2");
    bus.dmem_ready_i = 1'b1;
    check(V_WAIT_DONE, "store_ready");
    clear_in();
    check(V_NORMAL, "store_back_run");

    // redirect
    mem_redirect_i = 1'b1;
    check(V_REDIR, "redirect");
    mem_redirect_i = 1'b0;
    check(V_REDIR_ST, "redirect_state");
    check(V_NORMAL, "redirect_back_run");

    // redirect with a load-use pattern present: load-use suppressed
    mem_redirect_i = 1'b1;
    ex_memread_i = 1'b1; ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_uses_rs1_i = 1'b1;
    check(V_REDIR, "redirect_over_loaduse");
    mem_redirect_i = 1'b0;
    check(V_REDIR_ST, "redirect_state_no_loaduse");
    clear_in();
    check(V_NORMAL, "after_redirect_run");

    // redirect arriving in the completing MEM_WAIT cycle
    mem_memwrite_i = 1'b1;
    check(V_MEM_STALL, "wait_redir_stall");
    bus.dmem_ready_i = 1'b1; mem_redirect_i = 1'b1;
    check(mk(1'b1, 5'b11111, 4'b1110, 2'd1), "wait_ready_redirect");
    clear_in();
    check(V_REDIR_ST, "wait_redir_state");

    // reset while in MEM_WAIT; later ready ignored
    mem_memread_i = 1'b1;
    check(V_MEM_STALL, "rst_wait_stall");
    check(V_WAIT, "rst_wait_wait");
    reset_i = 1'b1;
    check(V_RESET, "rst_in_wait");
    clear_in();
    bus.dmem_ready_i = 1'b1;
    check(V_NORMAL, "rst_ready_ignored");
    clear_in();

`ifdef PIPE_CTRL_TIMEOUT_EN
    // ready never arrives: abort on the 8th MEM_WAIT cycle
    mem_memread_i = 1'b1;
    check(V_MEM_STALL, "to_stall");
    for (int i = 0; i < 7; i++) check(V_WAIT, "to_wait");
    check(mk(1'b0, 5'b11111, 4'b0000, 2'd1), "to_abort");
    clear_in();
    exp_timeout = 1'b1;
    check(V_NORMAL, "to_sticky0");
    check(V_NORMAL, "to_sticky1");
    reset_i = 1'b1;
    exp_timeout = 1'b0;
    check(V_RESET, "to_reset");
    clear_in();
    check(V_NORMAL, "to_cleared");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
